// File: rtl/countdown_timer_bcd_if.sv
// Handshake-free signal bundle for the BCD countdown timer.
// master drives the controls, slave is the timer itself.
interface countdown_timer_bcd_if #(
    parameter int CNT_W  = 8,
    parameter int DIGITS = 3
);
    logic                  tick;
    logic                  enable;
    logic                  load;
    logic [CNT_W-1:0]      load_val;
    logic                  auto_reload;
    logic [CNT_W-1:0]      count;
    logic                  flag_pre;
    logic                  done;
    logic [4*DIGITS-1:0]   number_BCD;
    logic                  bcd_valid;

    modport master (
        output tick, enable, load, load_val, auto_reload,
        input  count, flag_pre, done, number_BCD, bcd_valid
    );

    modport slave (
        input  tick, enable, load, load_val, auto_reload,
        output count, flag_pre, done, number_BCD, bcd_valid
    );
endinterface

// File: rtl/countdown_timer_bcd.sv
// Tick-driven countdown timer with one-shot/auto-reload and
// a sequential double-dabble BCD display converter.
module countdown_timer_bcd #(
    parameter int CNT_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_N,
    countdown_timer_bcd_if.slave  bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(CNT_W);

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam longint P10  = pow10(DIGITS);
    localparam longint MAXV = (64'd1 << CNT_W) - 1;

    if (CNT_W < 2 || CNT_W > 16) begin : g_bad_w
        $error("CNT_W must be in 2..16");
    end
    if (P10 <= MAXV) begin : g_bad_d
        $error("DIGITS too small for CNT_W");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } tmr_st_t;

    typedef enum logic [1:0] {
        CV_IDLE  = 2'd0,
        CV_SHIFT = 2'd1,
        CV_DONE  = 2'd2
    } cv_st_t;

    tmr_st_t           st_q, st_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;

    cv_st_t            cv_q, cv_d;
    logic [CNT_W-1:0]  snap_q, last_q, bin_q;
    logic [BW-1:0]     bcd_q, num_q;
    logic [CW-1:0]     cv_cnt_q;
    logic              fresh_q;
    logic              cv_start;

    function automatic logic [BW-1:0] add3(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Timer state, count and expiry pulse registers
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            st_q   <= IDLE;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // Timer next state: enable low > load > tick
    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (!bus.enable) begin
            cnt_d = bus.load_val;
            st_d  = IDLE;
        end else if (bus.load) begin
            cnt_d = bus.load_val;
            st_d  = RUN;
        end else begin
            unique case (st_q)
                IDLE: st_d = RUN;
                RUN: begin
                    if (bus.tick) begin
                        if (cnt_q > bus.load_val) begin
                            cnt_d = bus.load_val;
                        end else if (cnt_q == '0) begin
                            if (bus.load_val != '0) cnt_d = bus.load_val;
                        end else if (cnt_q == CNT_W'(1)) begin
                            cnt_d  = '0;
                            done_d = 1'b1;
                            st_d   = bus.auto_reload ? RUN : EXPIRED;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                EXPIRED: cnt_d = '0;
                default: st_d = IDLE;
            endcase
        end
    end

    assign cv_start = fresh_q || (cnt_q != last_q);

    // Converter state register
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) cv_q <= CV_IDLE;
        else        cv_q <= cv_d;
    end

    // Converter next state
    always_comb begin
        cv_d = cv_q;
        unique case (cv_q)
            CV_IDLE:  if (cv_start) cv_d = CV_SHIFT;
            CV_SHIFT: if (cv_cnt_q == '0) cv_d = CV_DONE;
            CV_DONE:  cv_d = CV_IDLE;
            default:  cv_d = CV_IDLE;
        endcase
    end

    // Double-dabble datapath: snapshot, add-3/shift, atomic publish
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            snap_q   <= '0;
            last_q   <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
            num_q    <= '0;
            cv_cnt_q <= '0;
            fresh_q  <= 1'b1;
        end else begin
            unique case (cv_q)
                CV_IDLE: begin
                    if (cv_start) begin
                        snap_q   <= cnt_q;
                        bin_q    <= cnt_q;
                        bcd_q    <= '0;
                        cv_cnt_q <= CW'(CNT_W - 1);
                        fresh_q  <= 1'b0;
                    end
                end
                CV_SHIFT: begin
                    {bcd_q, bin_q} <= {add3(bcd_q), bin_q} << 1;
                    cv_cnt_q       <= cv_cnt_q - CW'(1);
                end
                CV_DONE: begin
                    num_q  <= bcd_q;
                    last_q <= snap_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.count      = cnt_q;
    assign bus.done       = done_q;
    assign bus.flag_pre   = (st_q == RUN) && (cnt_q == CNT_W'(1));
    assign bus.number_BCD = num_q;
    assign bus.bcd_valid  = (cv_q == CV_IDLE) && !fresh_q
                            && (snap_q == cnt_q);
endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed self-checking bench for countdown_timer_bcd.
// Table of single-cycle vectors plus multi-cycle sequences.
module tb_countdown_timer_bcd;
    logic clk;
    logic rst_N;
    int   checks;
    int   errors;

    countdown_timer_bcd_if #(.CNT_W(8), .DIGITS(3)) bus ();

    countdown_timer_bcd #(.CNT_W(8), .DIGITS(3)) dut (
        .clk   (clk),
        .rst_N (rst_N),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       ld;
        logic       tk;
        logic       ar;
        logic [7:0] lv;
        logic [7:0] cnt;
        logic       dn;
        logic       fp;
    } vec_t;

    vec_t tbl [20];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [11:0] bcd_of(input int v);
        logic [3:0] d2, d1, d0;
        d2 = 4'((v / 100) % 10);
        d1 = 4'((v / 10) % 10);
        d0 = 4'(v % 10);
        return {d2, d1, d0};
    endfunction

    task automatic pulse_tick();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
    endtask

    task automatic wait_valid(input int lim);
        int n;
        n = 0;
        while (bus.bcd_valid !== 1'b1 && n < lim) begin
            step();
            n++;
        end
        chk("bcd_valid_wait", 32'(bus.bcd_valid), 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_N           = 1'b0;
        bus.tick        = 1'b0;
        bus.enable      = 1'b0;
        bus.load        = 1'b0;
        bus.load_val    = 8'd0;
        bus.auto_reload = 1'b1;

        //             en   ld   tk   ar   lv     cnt    dn   fp
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b1,8'd3,  8'd3,  1'b0,1'b0};
        tbl[1]  = '{1'b1,1'b0,1'b0,1'b1,8'd3,  8'd3,  1'b0,1'b0};
        tbl[2]  = '{1'b1,1'b0,1'b1,1'b1,8'd3,  8'd2,  1'b0,1'b0};
        tbl[3]  = '{1'b1,1'b0,1'b0,1'b1,8'd3,  8'd2,  1'b0,1'b0};
        tbl[4]  = '{1'b1,1'b0,1'b1,1'b1,8'd3,  8'd1,  1'b0,1'b1};
        tbl[5]  = '{1'b1,1'b0,1'b1,1'b1,8'd3,  8'd0,  1'b1,1'b0};
        tbl[6]  = '{1'b1,1'b0,1'b0,1'b1,8'd3,  8'd0,  1'b0,1'b0};
        tbl[7]  = '{1'b1,1'b0,1'b1,1'b1,8'd3,  8'd3,  1'b0,1'b0};
        tbl[8]  = '{1'b1,1'b0,1'b1,1'b1,8'd3,  8'd2,  1'b0,1'b0};
        tbl[9]  = '{1'b1,1'b0,1'b1,1'b1,8'd3,  8'd1,  1'b0,1'b1};
        tbl[10] = '{1'b1,1'b0,1'b1,1'b1,8'd3,  8'd0,  1'b1,1'b0};
        tbl[11] = '{1'b1,1'b0,1'b1,1'b1,8'd3,  8'd3,  1'b0,1'b0};
        tbl[12] = '{1'b1,1'b1,1'b1,1'b1,8'd7,  8'd7,  1'b0,1'b0};
        tbl[13] = '{1'b1,1'b0,1'b1,1'b1,8'd7,  8'd6,  1'b0,1'b0};
        tbl[14] = '{1'b1,1'b0,1'b1,1'b1,8'd4,  8'd4,  1'b0,1'b0};
        tbl[15] = '{1'b0,1'b1,1'b1,1'b1,8'd9,  8'd9,  1'b0,1'b0};
        tbl[16] = '{1'b1,1'b0,1'b1,1'b1,8'd9,  8'd9,  1'b0,1'b0};
        tbl[17] = '{1'b1,1'b0,1'b1,1'b1,8'd0,  8'd0,  1'b0,1'b0};
        tbl[18] = '{1'b1,1'b0,1'b1,1'b1,8'd0,  8'd0,  1'b0,1'b0};
        tbl[19] = '{1'b1,1'b0,1'b1,1'b1,8'd5,  8'd5,  1'b0,1'b0};

        #12;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_flag_pre", 32'(bus.flag_pre), 32'd0);
        chk("rst_bcd", 32'(bus.number_BCD), 32'd0);
        chk("rst_bcd_valid", 32'(bus.bcd_valid), 32'd0);
        step();
        rst_N = 1'b1;

        for (int i = 0; i < 20; i++) begin
            bus.enable      = tbl[i].en;
            bus.load        = tbl[i].ld;
            bus.tick        = tbl[i].tk;
            bus.auto_reload = tbl[i].ar;
            bus.load_val    = tbl[i].lv;
            step();
            chk($sformatf("vec%0d_count", i), 32'(bus.count),
                32'(tbl[i].cnt));
            chk($sformatf("vec%0d_done", i), 32'(bus.done),
                32'(tbl[i].dn));
            chk($sformatf("vec%0d_flag_pre", i), 32'(bus.flag_pre),
                32'(tbl[i].fp));
        end
        bus.load = 1'b0;
        bus.tick = 1'b0;

        // preset while disabled, display follows
        bus.enable   = 1'b0;
        bus.load_val = 8'd25;
        step();
        chk("preset_count", 32'(bus.count), 32'd25);
        wait_valid(30);
        chk("preset_bcd", 32'(bus.number_BCD), 32'h025);

        // one-shot countdown, ticks every 16 clks
        bus.enable      = 1'b1;
        bus.auto_reload = 1'b0;
        step();
        chk("run_entry_count", 32'(bus.count), 32'd25);
        for (int k = 24; k >= 0; k--) begin
            pulse_tick();
            chk($sformatf("os_count_%0d", k), 32'(bus.count), 32'(k));
            chk($sformatf("os_done_%0d", k), 32'(bus.done),
                32'(k == 0));
            chk($sformatf("os_flag_%0d", k), 32'(bus.flag_pre),
                32'(k == 1));
            step();
            chk($sformatf("os_done_clr_%0d", k), 32'(bus.done), 32'd0);
            repeat (14) step();
            chk($sformatf("os_bcd_%0d", k), 32'(bus.number_BCD),
                32'(bcd_of(k)));
            chk($sformatf("os_valid_%0d", k), 32'(bus.bcd_valid), 32'd1);
        end
        for (int k = 0; k < 3; k++) begin
            pulse_tick();
            chk("expired_count", 32'(bus.count), 32'd0);
            chk("expired_done", 32'(bus.done), 32'd0);
            chk("expired_flag", 32'(bus.flag_pre), 32'd0);
        end

        // load from EXPIRED, then load beats tick
        bus.load_val = 8'd10;
        bus.load     = 1'b1;
        step();
        bus.load = 1'b0;
        chk("exp_load_count", 32'(bus.count), 32'd10);
        repeat (3) pulse_tick();
        chk("pre_load_count", 32'(bus.count), 32'd7);
        bus.load_val = 8'd200;
        bus.load     = 1'b1;
        bus.tick     = 1'b1;
        step();
        bus.load = 1'b0;
        bus.tick = 1'b0;
        chk("load_vs_tick", 32'(bus.count), 32'd200);
        wait_valid(30);
        chk("load_bcd", 32'(bus.number_BCD), 32'h200);

        // shrink load_val while running at 40
        bus.load_val = 8'd40;
        bus.load     = 1'b1;
        step();
        bus.load = 1'b0;
        chk("load40", 32'(bus.count), 32'd40);
        bus.load_val = 8'd10;
        pulse_tick();
        chk("shrink_count", 32'(bus.count), 32'd10);
        chk("shrink_done", 32'(bus.done), 32'd0);

        // fast ticks every 2 clks
        bus.load_val = 8'd50;
        bus.load     = 1'b1;
        step();
        bus.load = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            pulse_tick();
            chk($sformatf("fast_count_%0d", i), 32'(bus.count),
                32'(50 - i));
            chk($sformatf("fast_valid_%0d", i), 32'(bus.bcd_valid),
                32'd0);
            step();
        end
        wait_valid(30);
        chk("fast_final_count", 32'(bus.count), 32'd30);
        chk("fast_final_bcd", 32'(bus.number_BCD), 32'h030);

        // async reset mid-conversion
        pulse_tick();
        step();
        step();
        rst_N = 1'b0;
        #1;
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        chk("mid_rst_flag", 32'(bus.flag_pre), 32'd0);
        chk("mid_rst_bcd", 32'(bus.number_BCD), 32'd0);
        chk("mid_rst_valid", 32'(bus.bcd_valid), 32'd0);
        step();
        rst_N = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
